// File: rtl/lzrw1_decomp_output.sv
// -----------------------------------------------------------------------------
// lzrw1_decomp_output
//
// LZRW1 decompressor back end. Takes already-decoded literal/copy tokens from
// the token parser and rebuilds the original byte stream. Every emitted byte
// is also written into a circular history window so that later copy tokens
// can reach back into it. Output is one byte per cycle through a single
// valid/ready output register.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   tok_valid    in   token present
//   tok_ready    out  token accepted when tok_valid && tok_ready
//   tok_is_copy  in   1 = copy token, 0 = literal token
//   tok_literal  in   literal byte (ignored for copies)
//   tok_offset   in   copy distance back from the next write position
//   tok_length   in   copy length minus 3 (actual length 3..18)
//   out_valid    out  out_byte valid
//   out_ready    in   sink accepts out_byte
//   out_byte     out  reconstructed byte
//   byte_count   out  bytes emitted since reset, wraps modulo 2^32
//   err_offset   out  sticky illegal-offset flag, cleared only by reset
//   Done         out  idle with no byte pending
//
// HISTORY must equal 2**OFFSET_W so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module lzrw1_decomp_output #(
    parameter int HISTORY  = 4096,
    parameter int OFFSET_W = 12
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tok_valid,
    output logic                tok_ready,
    input  logic                tok_is_copy,
    input  logic [7:0]          tok_literal,
    input  logic [OFFSET_W-1:0] tok_offset,
    input  logic [3:0]          tok_length,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_byte,
    output logic [31:0]         byte_count,
    output logic                err_offset,
    output logic                Done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_COPY = 1'b1
    } state_t;

    // fill saturates at exactly HISTORY, hence one extra bit
    localparam logic [OFFSET_W:0]   FILL_MAX = {1'b1, {OFFSET_W{1'b0}}};
    localparam logic [OFFSET_W:0]   FILL_ONE = {{OFFSET_W{1'b0}}, 1'b1};
    localparam logic [OFFSET_W-1:0] PTR_ONE  = {{(OFFSET_W-1){1'b0}}, 1'b1};
    localparam logic [OFFSET_W-1:0] PTR_ZERO = {OFFSET_W{1'b0}};

    // History window: deliberately not reset; fill_q == 0 makes it unreachable.
    logic [7:0]          hist_q [0:HISTORY-1];

    state_t              state_q,      state_d;
    logic                out_valid_q,  out_valid_d;
    logic [7:0]          out_byte_q,   out_byte_d;
    logic [OFFSET_W-1:0] wptr_q,       wptr_d;
    logic [OFFSET_W-1:0] src_q,        src_d;
    logic [OFFSET_W:0]   fill_q,       fill_d;
    logic [4:0]          remaining_q,  remaining_d;
    logic [31:0]         byte_count_q, byte_count_d;
    logic                err_q,        err_d;
    logic                done_q,       done_d;

    logic                out_free_s;
    logic                tok_ready_s;
    logic                tok_accept_s;
    logic                offset_legal_s;
    logic [OFFSET_W-1:0] copy_src_s;
    logic [OFFSET_W-1:0] rd_addr_s;
    logic [7:0]          rd_byte_s;
    logic                emit_s;
    logic [7:0]          emit_byte_s;

    // Handshake qualifiers and the history read port.
    always_comb begin
        out_free_s     = !out_valid_q || out_ready;
        tok_accept_s   = tok_valid && tok_ready_s;
        offset_legal_s = (tok_offset != PTR_ZERO) && ({1'b0, tok_offset} <= fill_q);
        copy_src_s     = wptr_q - tok_offset;
        // The first copy byte is read straight from the token's offset; the
        // rest follow src_q. The write to hist is registered, so with
        // offset >= 1 the read always sees a byte stored on an earlier cycle,
        // which is what makes overlapping copies replicate the pattern.
        if (state_q == ST_COPY) begin
            rd_addr_s = src_q;
        end else begin
            rd_addr_s = copy_src_s;
        end
        rd_byte_s = hist_q[rd_addr_s];
    end

    // Token FSM next-state logic and the shared byte-emit datapath.
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_byte_d   = out_byte_q;
        wptr_d       = wptr_q;
        src_d        = src_q;
        fill_d       = fill_q;
        remaining_d  = remaining_q;
        byte_count_d = byte_count_q;
        err_d        = err_q;
        tok_ready_s  = 1'b0;
        emit_s       = 1'b0;
        emit_byte_s  = 8'h00;

        case (state_q)
            ST_IDLE: begin
                tok_ready_s = out_free_s;
                if (tok_accept_s) begin
                    if (!tok_is_copy) begin
                        emit_s      = 1'b1;
                        emit_byte_s = tok_literal;
                    end else if (offset_legal_s) begin
                        emit_s      = 1'b1;
                        emit_byte_s = rd_byte_s;
                        src_d       = copy_src_s + PTR_ONE;
                        // first byte goes out now; L-1 = tok_length + 2 remain
                        remaining_d = {1'b0, tok_length} + 5'd2;
                        state_d     = ST_COPY;
                    end else begin
                        // illegal copy is consumed silently apart from the flag
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COPY: begin
                if (out_free_s) begin
                    emit_s      = 1'b1;
                    emit_byte_s = rd_byte_s;
                    src_d       = src_q + PTR_ONE;
                    remaining_d = remaining_q - 5'd1;
                    if (remaining_q == 5'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_COPY;
                    end
                end else begin
                    state_d = ST_COPY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (emit_s) begin
            out_valid_d  = 1'b1;
            out_byte_d   = emit_byte_s;
            wptr_d       = wptr_q + PTR_ONE;
            byte_count_d = byte_count_q + 32'd1;
            if (fill_q == FILL_MAX) begin
                fill_d = fill_q;
            end else begin
                fill_d = fill_q + FILL_ONE;
            end
        end else if (out_free_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        done_d = (state_d == ST_IDLE) && !out_valid_d;
    end

    // Control and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_byte_q   <= 8'h00;
            wptr_q       <= PTR_ZERO;
            src_q        <= PTR_ZERO;
            fill_q       <= {(OFFSET_W+1){1'b0}};
            remaining_q  <= 5'd0;
            byte_count_q <= 32'd0;
            err_q        <= 1'b0;
            done_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_byte_q   <= out_byte_d;
            wptr_q       <= wptr_d;
            src_q        <= src_d;
            fill_q       <= fill_d;
            remaining_q  <= remaining_d;
            byte_count_q <= byte_count_d;
            err_q        <= err_d;
            done_q       <= done_d;
        end
    end

    // History write: every emitted byte lands at the write pointer.
    always_ff @(posedge clock) begin
        if (emit_s) begin
            hist_q[wptr_q] <= emit_byte_s;
        end
    end

    assign tok_ready  = tok_ready_s;
    assign out_valid  = out_valid_q;
    assign out_byte   = out_byte_q;
    assign byte_count = byte_count_q;
    assign err_offset = err_q;
    assign Done       = done_q;

endmodule

// File: tb/tb_lzrw1_decomp_output.sv
module tb_lzrw1_decomp_output;

    logic        clock;
    logic        reset;
    logic        tok_valid;
    logic        tok_ready;
    logic        tok_is_copy;
    logic [7:0]  tok_literal;
    logic [11:0] tok_offset;
    logic [3:0]  tok_length;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic [31:0] byte_count;
    logic        err_offset;
    logic        Done;

    int          checks_r;
    int          errors_r;
    logic [7:0]  rx_q[$];
    bit          toggle_r;
    bit          stalled_r;
    logic [7:0]  held_r;

    lzrw1_decomp_output #(.HISTORY(4096), .OFFSET_W(12)) dut (
        .clock       (clock),
        .reset       (reset),
        .tok_valid   (tok_valid),
        .tok_ready   (tok_ready),
        .tok_is_copy (tok_is_copy),
        .tok_literal (tok_literal),
        .tok_offset  (tok_offset),
        .tok_length  (tok_length),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_byte    (out_byte),
        .byte_count  (byte_count),
        .err_offset  (err_offset),
        .Done        (Done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Byte collector plus stall-hold observer, sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset) begin
            if (stalled_r) begin
                check_value("stall_valid_hold", {31'd0, out_valid}, 32'd1);
                check_value("stall_byte_hold", {24'd0, out_byte}, {24'd0, held_r});
            end
            if (out_valid && out_ready) rx_q.push_back(out_byte);
            stalled_r = out_valid && !out_ready;
            held_r    = out_byte;
        end else begin
            stalled_r = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (toggle_r) out_ready = ~out_ready;
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clock);
        #3;
        reset     = 1'b1;
        toggle_r  = 1'b0;
        out_ready = 1'b1;
        tok_valid = 1'b0;
        #4;
        reset = 1'b0;
        tick();
        rx_q.delete();
    endtask

    // Present a token, wait (bounded) for acceptance; returns 2 time units after the accepting edge.
    task automatic send_tok(input bit is_copy, input logic [7:0] lit, input logic [11:0] off, input logic [3:0] len);
        int n;
        tok_is_copy = is_copy;
        tok_literal = lit;
        tok_offset  = off;
        tok_length  = len;
        tok_valid   = 1'b1;
        n = 0;
        while (!tok_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check_value("tok_accept_timeout", 32'd0, 32'd1);
        tick();
        tok_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!Done && n < 200) begin
            tick();
            n++;
        end
        check_value("done_timeout", {31'd0, Done}, 32'd1);
    endtask

    initial begin
        logic [7:0] abcd [4];
        checks_r    = 0;
        errors_r    = 0;
        toggle_r    = 1'b0;
        stalled_r   = 1'b0;
        held_r      = 8'h00;
        reset       = 1'b1;
        tok_valid   = 1'b0;
        tok_is_copy = 1'b0;
        tok_literal = 8'h00;
        tok_offset  = 12'd0;
        tok_length  = 4'd0;
        out_ready   = 1'b1;
        abcd[0] = 8'h41; abcd[1] = 8'h42; abcd[2] = 8'h43; abcd[3] = 8'h44;

        // reset state
        #12;
        check_value("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_value("rst_out_byte", {24'd0, out_byte}, 32'd0);
        check_value("rst_byte_count", byte_count, 32'd0);
        check_value("rst_err", {31'd0, err_offset}, 32'd0);
        check_value("rst_done", {31'd0, Done}, 32'd1);
        check_value("rst_tok_ready", {31'd0, tok_ready}, 32'd1);
        apply_reset();

        // literal stream ABCD, latency 1, back to back
        for (int i = 0; i < 4; i++) begin
            send_tok(1'b0, abcd[i], 12'd0, 4'd0);
            check_value("lit_valid", {31'd0, out_valid}, 32'd1);
            check_value("lit_byte", {24'd0, out_byte}, {24'd0, abcd[i]});
            check_value("lit_count", byte_count, i + 1);
        end
        tick();
        check_value("lit_idle_valid", {31'd0, out_valid}, 32'd0);
        check_value("lit_done", {31'd0, Done}, 32'd1);
        check_value("lit_total", byte_count, 32'd4);

        // 'A' then overlapping copy offset 1, L=5
        apply_reset();
        send_tok(1'b0, 8'h41, 12'd0, 4'd0);
        send_tok(1'b1, 8'h00, 12'd1, 4'd2);
        check_value("cpy1_first", {24'd0, out_byte}, 32'h41);
        for (int i = 0; i < 4; i++) begin
            check_value("cpy1_ready_low", {31'd0, tok_ready}, 32'd0);
            tick();
        end
        check_value("cpy1_ready_back", {31'd0, tok_ready}, 32'd1);
        wait_done();
        check_value("cpy1_len", rx_q.size(), 32'd6);
        for (int i = 0; i < rx_q.size(); i++) check_value("cpy1_byte", {24'd0, rx_q[i]}, 32'h41);
        check_value("cpy1_count", byte_count, 32'd6);

        // "abc" then copy offset 3, L=18, with sink toggling
        apply_reset();
        send_tok(1'b0, 8'h61, 12'd0, 4'd0);
        send_tok(1'b0, 8'h62, 12'd0, 4'd0);
        send_tok(1'b0, 8'h63, 12'd0, 4'd0);
        toggle_r = 1'b1;
        send_tok(1'b1, 8'h00, 12'd3, 4'd15);
        wait_done();
        toggle_r  = 1'b0;
        out_ready = 1'b1;
        check_value("cpy3_len", rx_q.size(), 32'd21);
        for (int i = 0; i < rx_q.size(); i++) check_value("cpy3_byte", {24'd0, rx_q[i]}, 32'h61 + (i % 3));
        check_value("cpy3_count", byte_count, 32'd21);

        // illegal offsets
        apply_reset();
        send_tok(1'b0, 8'h58, 12'd0, 4'd0);
        send_tok(1'b1, 8'h00, 12'd0, 4'd0);
        check_value("err0_flag", {31'd0, err_offset}, 32'd1);
        check_value("err0_no_out", {31'd0, out_valid}, 32'd0);
        send_tok(1'b1, 8'h00, 12'd2, 4'd0);
        check_value("err2_no_out", {31'd0, out_valid}, 32'd0);
        check_value("err2_count", byte_count, 32'd1);
        send_tok(1'b0, 8'h59, 12'd0, 4'd0);
        check_value("err_lit_byte", {24'd0, out_byte}, 32'h59);
        check_value("err_sticky", {31'd0, err_offset}, 32'd1);
        check_value("err_count", byte_count, 32'd2);

        // wrap: 4100 literals then copy offset 4095
        apply_reset();
        for (int i = 0; i < 4100; i++) send_tok(1'b0, 8'(i % 251), 12'd0, 4'd0);
        tick();
        rx_q.delete();
        send_tok(1'b1, 8'h00, 12'd4095, 4'd0);
        wait_done();
        check_value("wrap_len", rx_q.size(), 32'd3);
        for (int i = 0; i < rx_q.size(); i++) check_value("wrap_byte", {24'd0, rx_q[i]}, 32'd5 + i);
        check_value("wrap_err", {31'd0, err_offset}, 32'd0);
        check_value("wrap_count", byte_count, 32'd4103);

        // async reset in the middle of an 18-byte copy
        apply_reset();
        send_tok(1'b0, 8'h51, 12'd0, 4'd0);
        send_tok(1'b1, 8'h00, 12'd1, 4'd15);
        tick();
        tick();
        check_value("mid_count", byte_count, 32'd4);
        #3;
        reset = 1'b1;
        #1;
        check_value("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_value("mid_rst_count", byte_count, 32'd0);
        check_value("mid_rst_ready", {31'd0, tok_ready}, 32'd1);
        #1;
        reset = 1'b0;
        tick();
        send_tok(1'b1, 8'h00, 12'd1, 4'd0);
        check_value("post_rst_err", {31'd0, err_offset}, 32'd1);
        check_value("post_rst_no_out", {31'd0, out_valid}, 32'd0);
        check_value("post_rst_count", byte_count, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule

// File: doc/lzrw1_decomp_output.md
# lzrw1_decomp_output

LZRW1 decompressor back end: accepts decoded literal/copy tokens and rebuilds the original byte stream from a circular history window. Mirrors the compressor input stage: the history the compressor searched with `offset`/`Length` is rebuilt here and replayed one byte per cycle. Sits between the control-word/token parser and the output byte sink.

## Interface
- `HISTORY`, 4096: history window depth in bytes; power of two.
- `OFFSET_W`, 12: offset width; `2**OFFSET_W == HISTORY`.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `tok_valid` in 1: token present.
- `tok_ready` out 1: token accepted on a cycle with `tok_valid && tok_ready`.
- `tok_is_copy` in 1: 1 = copy token, 0 = literal token.
- `tok_literal` in 8: literal byte; ignored for copies.
- `tok_offset` in OFFSET_W: copy distance back from the next write position; valid range 1..fill.
- `tok_length` in 4: copy length minus 3; actual length 3..18.
- `out_valid` out 1: `out_byte` valid.
- `out_ready` in 1: sink accepts the byte.
- `out_byte` out 8: reconstructed byte.
- `byte_count` out 32: total bytes emitted since reset; wraps modulo 2^32.
- `err_offset` out 1: sticky; set by an illegal copy offset.
- `Done` out 1: high in IDLE with `out_valid` low.

## Operation
- Storage: `HISTORY` x 8 register array, write pointer `wptr` (OFFSET_W bits, wraps naturally), saturating `fill` counter (0..HISTORY). History contents are not cleared on reset. With `fill` = 0, they are unreachable.
- Output register advances when `out_free = !out_valid || out_ready`.
  - When `out_free` and no byte is produced, `out_valid` goes low.
- IDLE:
  - `tok_ready = out_free`.
  - Literal accepted: `out_byte <= tok_literal`, `out_valid <= 1`, `hist[wptr] <= tok_literal`, `wptr++`, `fill++` (saturating), `byte_count++`. Stay in IDLE.
  - Legal copy accepted (`1 <= tok_offset <= fill`):
    - `src = wptr - tok_offset` (mod HISTORY).
    - Emit `hist[src]`, write the same byte to `hist[wptr]`, advance both pointers.
    - `remaining <= tok_length + 2`. Go to COPY.
  - Illegal copy accepted (`tok_offset == 0` or `tok_offset > fill`): token is consumed, `err_offset <= 1`, nothing emitted, no history change. Stay in IDLE.
- COPY:
  - `tok_ready = 0`.
  - Each cycle with `out_free`: emit `hist[src]`, write `hist[wptr]`, `src++`, `wptr++`, `fill++` (saturating), `byte_count++`, `remaining--`.
  - When the emitting cycle has `remaining == 1`, return to IDLE.
  - When `!out_free`, hold all state.
- Overlapping copies (offset < length) must replicate the pattern. The array write is registered, so `hist[src]` always reads a byte written on an earlier cycle; offset >= 1 guarantees this.
- Wrap-around: `src` and `wptr` wrap modulo HISTORY. Once `fill == HISTORY`, any offset 1..HISTORY-1 is legal.
- `err_offset` clears only on reset. Operation continues after an error.

## Timing
- Reset (async assert) forces:
  - state = IDLE
  - `out_valid` = 0, `out_byte` = 0
  - `wptr` = 0, `fill` = 0, `remaining` = 0
  - `byte_count` = 0, `err_offset` = 0
  - `Done` = 1, `tok_ready` = 1
- Literal accepted at edge N: byte visible from N+1, i.e. latency 1.
- Copy of length L accepted at edge N: bytes visible at N+1..N+L with no stall; `tok_ready` is low for L-1 cycles after acceptance. Throughput is 1 byte/cycle sustained.
- Back-to-back literals: one per cycle while `out_ready` = 1.
- Sink stall (`out_ready` = 0 with `out_valid` = 1): `out_byte`, `out_valid`, pointers and counters hold; `tok_ready` = 0.
- Reset mid-copy: the remaining bytes are dropped. The first token after deassertion is treated as stream start, so `fill` = 0 and any copy is illegal until literals arrive.
- `byte_count` updates on the same edge that loads `out_byte`.

## Test plan
- Literal stream "ABCD" with `out_ready` = 1 -> `out_byte` A,B,C,D on consecutive cycles N+1..N+4; `byte_count` = 4; `Done` = 1 at N+5.
- Literal 'A' then copy offset 1, tok_length 2 (L=5) -> A,A,A,A,A,A; `tok_ready` low 4 cycles after copy accept.
- Literals "abc" then copy offset 3, tok_length 15 (L=18) with `out_ready` toggling every other cycle -> "abc" repeated six times after the literals, exact order; bytes hold while stalled; 21 bytes total.
- Literal 'X', then copy offset 0 -> `err_offset` = 1, no output. Then copy offset 2 with `fill` = 1 -> no output. Then literal 'Y' -> output 'Y'; `err_offset` stays 1.
- 4100 literals (value i mod 251), then copy offset 4095, tok_length 0 -> emits the values from positions 5, 6, 7 (i.e. 5, 6, 7), exercising the wrap.
- Assert `reset` asynchronously mid 18-byte copy, between edges -> `out_valid` = 0 and `byte_count` = 0 immediately. After release, a copy offset 1 -> `err_offset` = 1.
